// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
//   Debug read-out engine for the femtoRV32 register file. A start pulse walks
//   the spare read port from FIRST_REG to LAST_REG and streams each 32-bit
//   value little-endian over a valid/ready byte interface, framed by a HEADER
//   byte and a trailing XOR checksum of the register data bytes.
//
// Ports
//   clk       clock
//   rst       asynchronous, active-high reset
//   start     dump request, sampled only while idle
//   readReg   register-file read address
//   readData  combinational register-file read data for readReg
//   tx_data   byte presented to the sink
//   tx_valid  tx_data is valid
//   tx_ready  sink accepts the byte this cycle
//   busy      high whenever a frame is in progress (all states but IDLE)
//   done      one-cycle pulse at the end of a frame
module reg_dump_streamer #(
  parameter int unsigned    FIRST_REG = 0,
  parameter int unsigned    LAST_REG  = 31,
  parameter logic [7:0]     HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  readReg,
  input  logic [31:0] readData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    CHK,
    DONE
  } state_t;

  state_t      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  read_reg_q;
  logic [7:0]  chk_q;
  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  idx_d;
  logic [7:0]  chk_d;
  logic        hs;

  assign idx_d = idx_q + 5'd1;
  assign chk_d = chk_q ^ shift_q[7:0];
  assign hs    = tx_valid_q & tx_ready;

  // Outputs are loaded together with the state transition, so tx_data/tx_valid
  // already hold the value belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= FIRST;
      read_reg_q <= FIRST;
      chk_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q      <= FIRST;
            read_reg_q <= FIRST;
            chk_q      <= '0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          shift_q    <= readData;
          cnt_q      <= '0;
          tx_data_q  <= readData[7:0];
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (hs) begin
            chk_q   <= chk_d;
            shift_q <= shift_q >> 8;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (idx_q == LAST) begin
                // Checksum includes the byte being accepted right now.
                tx_data_q <= chk_d;
                state_q   <= CHK;
              end else begin
                idx_q      <= idx_d;
                read_reg_q <= idx_d;
                tx_data_q  <= '0;
                tx_valid_q <= 1'b0;
                state_q    <= LOAD;
              end
            end else begin
              tx_data_q <= shift_q[15:8];
            end
          end
        end
        CHK: begin
          if (hs) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_data_q  <= '0;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign readReg  = read_reg_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
module tb_reg_dump_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rf [32];

  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [4:0]  rr_a;
  logic [31:0] rd_a;
  logic [7:0]  data_a;

  logic        start_b, ready_b, valid_b, busy_b, done_b;
  logic [4:0]  rr_b;
  logic [31:0] rd_b;
  logic [7:0]  data_b;

  int checks = 0;
  int errors = 0;
  int hs_a = 0, hs_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  always #5 clk = ~clk;

  assign rd_a = (rr_a == 5'd0) ? 32'h0 : rf[rr_a];
  assign rd_b = (rr_b == 5'd0) ? 32'h0 : rf[rr_b];

  reg_dump_streamer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .readReg(rr_a), .readData(rd_a),
    .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .busy(busy_a), .done(done_a)
  );

  reg_dump_streamer #(.FIRST_REG(5), .LAST_REG(5), .HEADER(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .readReg(rr_b), .readData(rd_b),
    .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word_a(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) q_a.push_back(8'(w >> (8 * i)));
  endtask

  task automatic push_zero_words_a(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push_word_a(32'h0);
  endtask

  // Scoreboard monitors: pop and compare on every handshake.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      hs_a++;
      if (q_a.size() == 0) check("unexpected_byte_a", {24'h0, data_a}, 32'hFFFF_FFFF);
      else check("byte_a", {24'h0, data_a}, {24'h0, q_a.pop_front()});
    end
    if (done_a) done_cnt_a++;
  end

  logic       stall_prev_b = 1'b0;
  logic [7:0] data_prev_b  = 8'h0;
  always @(negedge clk) begin
    if (valid_b && ready_b) begin
      hs_b++;
      if (q_b.size() == 0) check("unexpected_byte_b", {24'h0, data_b}, 32'hFFFF_FFFF);
      else check("byte_b", {24'h0, data_b}, {24'h0, q_b.pop_front()});
    end
    if (stall_prev_b) begin
      check("stall_valid_b", {31'h0, valid_b}, 32'h1);
      check("stall_data_b", {24'h0, data_b}, {24'h0, data_prev_b});
    end
    stall_prev_b = valid_b && !ready_b;
    data_prev_b  = data_b;
    if (done_b) done_cnt_b++;
  end

  initial begin
    int done_cyc, done_cyc2, busy_low_cyc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_readReg_a", {27'h0, rr_a}, 32'd0);
    check("rst_readReg_b", {27'h0, rr_b}, 32'd5);
    check("rst_valid_a", {31'h0, valid_a}, 32'h0);
    check("rst_data_a", {24'h0, data_a}, 32'h0);
    check("rst_busy_a", {31'h0, busy_a}, 32'h0);
    check("rst_done_a", {31'h0, done_a}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Full dump with a second start mid-frame that must be ignored.
    rf[1] = 32'h1122_3344;
    @(posedge clk); #1;
    q_a.push_back(8'hA5); push_word_a(32'h0); push_word_a(32'h1122_3344);
    push_zero_words_a(30); q_a.push_back(8'h44);
    hs_a = 0; done_cnt_a = 0; done_cyc = -1;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start_a = (cyc == 50);
      if (cyc == 1) check("hdr_valid_cycle1", {31'h0, valid_a}, 32'h1);
      if (done_a && done_cyc < 0) done_cyc = cyc;
      if (cyc == 164) begin
        check("busy_low_164", {31'h0, busy_a}, 32'h0);
        check("valid_low_164", {31'h0, valid_a}, 32'h0);
      end
    end
    check("full_done_cycle", done_cyc, 163);
    check("full_done_count", done_cnt_a, 1);
    check("full_handshakes", hs_a, 130);
    check("full_queue_empty", q_a.size(), 0);

    // Writes during register 3's bytes: x3 keeps its captured value, x4 sees new.
    rf[1] = 32'h0; rf[3] = 32'hCAFE_BABE; rf[4] = 32'h0102_0304;
    @(posedge clk); #1;
    q_a.push_back(8'hA5); push_zero_words_a(3); push_word_a(32'hCAFE_BABE);
    push_word_a(32'h1234_5678); push_zero_words_a(27); q_a.push_back(8'h38);
    done_cnt_a = 0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 170; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (cyc == 19) begin rf[3] = 32'hFFFF_FFFF; rf[4] = 32'h1234_5678; end
    end
    check("write_done_count", done_cnt_a, 1);
    check("write_queue_empty", q_a.size(), 0);

    // Reset during the second data byte of x0: only A5 and one byte transfer.
    @(posedge clk); #1;
    q_a.push_back(8'hA5); q_a.push_back(8'h00);
    hs_a = 0; done_cnt_a = 0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, valid_a}, 32'h0);
    check("midrst_busy", {31'h0, busy_a}, 32'h0);
    check("midrst_done", {31'h0, done_a}, 32'h0);
    check("midrst_handshakes", hs_a, 2);
    check("midrst_queue_empty", q_a.size(), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Recovery frame followed by a back-to-back frame; checksum restarts at 0.
    @(posedge clk); #1;
    q_a.push_back(8'hA5); push_zero_words_a(3); push_word_a(32'hFFFF_FFFF);
    push_word_a(32'h1234_5678); push_zero_words_a(27); q_a.push_back(8'h08);
    hs_a = 0; done_cnt_a = 0; done_cyc = -1; done_cyc2 = -1; busy_low_cyc = -1;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a && done_cyc < 0) done_cyc = cyc;
      else if (done_a && done_cyc2 < 0) done_cyc2 = cyc;
      if (done_cyc > 0 && busy_low_cyc < 0 && !busy_a) begin
        busy_low_cyc = cyc;
        q_a.push_back(8'hA5); push_zero_words_a(3); push_word_a(32'hFFFF_FFFF);
        push_word_a(32'h1234_5678); push_zero_words_a(27); q_a.push_back(8'h08);
        start_a = 1'b1;
      end
    end
    check("b2b_done1_cycle", done_cyc, 163);
    check("b2b_idle_cycle", busy_low_cyc, 164);
    check("b2b_done2_cycle", done_cyc2, 327);
    check("b2b_done_count", done_cnt_a, 2);
    check("b2b_handshakes", hs_a, 260);
    check("b2b_queue_empty", q_a.size(), 0);

    // Backpressure on the single-register instance, tx_ready pattern 1-0-0-1.
    rf[5] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    q_b.push_back(8'hA5); q_b.push_back(8'hEF); q_b.push_back(8'hBE);
    q_b.push_back(8'hAD); q_b.push_back(8'hDE); q_b.push_back(8'h22);
    hs_b = 0; done_cnt_b = 0; done_cyc = -1;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      ready_b = (cyc % 4 == 0) || (cyc % 4 == 1);
      if (done_b && done_cyc < 0) done_cyc = cyc;
    end
    ready_b = 1'b0;
    check("bp_done_seen", {31'h0, done_cyc > 0}, 32'h1);
    check("bp_handshakes", hs_b, 6);
    check("bp_done_count", done_cnt_b, 1);
    check("bp_queue_empty", q_b.size(), 0);
    check("bp_busy_after", {31'h0, busy_b}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_streamer.md
# reg_dump_streamer

Debug read-out engine for the femtoRV32 register file. On a start pulse it walks the register file's read port through a configurable register range and streams each 32-bit value as little-endian bytes over a valid/ready byte interface. Each dump is framed by a header byte and a trailing XOR checksum. It sits beside the core on a spare read port (readReg/readData) and feeds a UART transmitter or debug FIFO.

## Interface

Parameters:
- FIRST_REG, default 0, first register index dumped (0..31).
- LAST_REG, default 31, last register index dumped (FIRST_REG..31).
- HEADER, default 8'hA5, frame-start byte.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  dump request; sampled in IDLE only.
- readReg  out  5  address to register-file read port.
- readData  in  32  combinational read data for readReg.
- tx_data  out  8  byte to sink.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of frame.

## Operation

- FSM states: IDLE, HDR, LOAD, SEND, CHK, DONE.
- IDLE:
  - On start=1: idx<=FIRST_REG, readReg<=FIRST_REG, chk<=0, go to HDR.
  - start=0: stay in IDLE.
- HDR: tx_valid=1, tx_data=HEADER. On handshake (tx_valid&tx_ready), go to LOAD.
- LOAD (1 cycle, tx_valid=0): shift<=readData, byte_cnt<=0, go to SEND.
- SEND: tx_valid=1, tx_data=shift[7:0]. On handshake:
  - chk<=chk^shift[7:0], shift<=shift>>8, byte_cnt<=byte_cnt+1.
  - If byte_cnt==3 and idx==LAST_REG, go to CHK.
  - If byte_cnt==3 otherwise: idx<=idx+1, readReg<=idx+1, go to LOAD.
- CHK: tx_valid=1, tx_data=chk (XOR of all register data bytes; the header is excluded). On handshake, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Frame length is 2+4*(LAST_REG-FIRST_REG+1) bytes.
- start while busy is ignored; it is not queued.
- A register write to the file during a dump: the value latched at that register's LOAD cycle is the value sent. Later writes do not alter bytes already captured.
- x0 is dumped like any other register and reads as 0.

## Timing

- Reset values: state=IDLE, readReg=FIRST_REG, tx_data=0, tx_valid=0, busy=0, done=0, idx=FIRST_REG, chk=0, shift=0.
- Reset mid-frame: the FSM returns to IDLE immediately (asynchronous) and tx_valid drops. The partial frame is abandoned; no checksum is sent.
- All outputs are decoded from registered state/data, so there are no combinational paths from inputs to outputs.
- Latency from start sampled at cycle 0 (IDLE) to header tx_valid=1 is cycle 1.
- With tx_ready held high and a full range of 32 registers:
  - Header at cycle 1.
  - Register k: LOAD at cycle 2+5k, bytes at cycles 3+5k..6+5k.
  - Checksum at cycle 162, done at cycle 163, IDLE (busy=0) at cycle 164.
- Handshake rule: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable indefinitely. A byte transfers only on a cycle where both are high.
- readReg is stable from LOAD entry through the end of that register's SEND bytes.

## Test plan

- Full dump, tx_ready=1: preload x1=0x11223344 and all other registers 0, pulse start.
  - Expected bytes: A5, then 00×4 (x0), then 44 33 22 11, then zeros, then checksum 0x44.
  - Total 130 bytes; done pulses at cycle 163.
- Backpressure: FIRST_REG=LAST_REG=5, x5=0xDEADBEEF, tx_ready toggling 1-0-0-1.
  - Expected bytes: A5 EF BE AD DE, then checksum 0x22.
  - tx_data is stable during every stall; exactly 6 handshakes occur.
- start ignored while busy: pulse start again mid-frame.
  - No restart; frame contents are unchanged; one done pulse only.
- Write during dump: while register 3 bytes are being sent, write x3=0xFFFFFFFF and x4=0x12345678.
  - Bytes for x3 are the old value; x4 is sent as 78 56 34 12.
- Reset mid-frame: assert rst during the second SEND byte.
  - tx_valid=0, busy=0, done=0 immediately.
  - A following start produces a complete, correct frame beginning with A5.
- Back-to-back: pulse start in the first IDLE cycle after done.
  - A second identical frame follows; the checksum resets to 0 for each frame.
